// File: rtl/counter_ctrl.sv
// Front-panel control for the 4-bit up/down counter: synchronises and debounces
// the buttons, tracks count direction and sequences Load / Count_en pulses.

module counter_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic nReset,
  input  logic raw,
  output logic evt
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          deb, deb_q;

  // evt is a registered rising edge of the debounced level, one cycle after it changes
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync  <= '0;
      cnt   <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      deb_q <= deb;
      evt   <= deb & ~deb_q;
    end
  end
endmodule

module counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Btn_load,
  input  logic       Btn_dir,
  input  logic       Btn_step,
  input  logic       Run,
  output logic       Load,
  output logic       Count_en,
  output logic       Up,
  output logic [1:0] Mode
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_LOAD = 2'b11
  } state_t;

  logic [2:0]    raw, evt;
  logic [1:0]    run_sync;
  logic          run_s, dir_tgl;
  state_t        state, nxt;
  logic [PW-1:0] presc, presc_nxt;

  assign raw   = {Btn_step, Btn_dir, Btn_load};
  assign run_s = run_sync[1];
  assign Mode  = state;

  for (genvar b = 0; b < 3; b++) begin : g_btn
    counter_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .Clk    (Clk),
      .nReset (nReset),
      .raw    (raw[b]),
      .evt    (evt[b])
    );
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (evt[0])      nxt = S_LOAD;
               else if (evt[2]) nxt = S_STEP;
               else if (run_s)  nxt = S_RUN;
      S_RUN:   if (evt[0])      nxt = S_LOAD;
               else if (!run_s) nxt = S_IDLE;
      S_STEP:  nxt = S_IDLE;
      S_LOAD:  nxt = run_s ? S_RUN : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Prescaler restarts from 0 on every entry into RUN
  always_comb begin
    presc_nxt = '0;
    if (state == S_RUN)
      presc_nxt = (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
  end

  // Outputs are registered from the next state so they line up with Mode
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= S_IDLE;
      presc    <= '0;
      run_sync <= '0;
      dir_tgl  <= 1'b0;
      Up       <= 1'b0;
      Load     <= 1'b0;
      Count_en <= 1'b0;
    end else begin
      state    <= nxt;
      presc    <= presc_nxt;
      run_sync <= {run_sync[0], Run};
      dir_tgl  <= evt[1];
      Up       <= Up ^ dir_tgl;
      Load     <= (nxt == S_LOAD);
      Count_en <= (nxt == S_STEP) ||
                  ((nxt == S_RUN) && (presc_nxt == PW'(TICK_DIV - 1)));
    end
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed + randomized bench for counter_ctrl against a cycle-indexed
// reference model built from button sample histories.

module tb_counter_ctrl;
  localparam int D    = 4;
  localparam int T    = 10;
  localparam int MAXC = 8192;

  logic       Clk = 1'b0, nReset = 1'b0;
  logic       Btn_load = 1'b0, Btn_dir = 1'b0, Btn_step = 1'b0, Run = 1'b0;
  logic       Load, Count_en, Up;
  logic [1:0] Mode;

  int vectors = 0, miscompares = 0;

  counter_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
    .Clk(Clk), .nReset(nReset), .Btn_load(Btn_load), .Btn_dir(Btn_dir),
    .Btn_step(Btn_step), .Run(Run), .Load(Load), .Count_en(Count_en),
    .Up(Up), .Mode(Mode)
  );

  always #5 Clk = ~Clk;

  // Reference model: k counts rising edges since reset release; everything the
  // control logic acts on at edge k is the raw input seen at edge k-2.
  bit rawh [3][MAXC];
  bit riseh[3][MAXC];
  bit runh [MAXC];
  bit lvl[3];
  int streak[3];
  int k, mmode, entry;
  bit mup;

  function automatic void model_reset();
    k = 0; mmode = 0; entry = 0; mup = 1'b0;
    for (int b = 0; b < 3; b++) begin lvl[b] = 1'b0; streak[b] = 0; end
  endfunction

  function automatic void model_edge();
    bit syn, rs, le, se, de;
    if (k >= MAXC) return;
    rawh[0][k] = Btn_load; rawh[1][k] = Btn_dir; rawh[2][k] = Btn_step;
    runh[k] = Run;
    for (int b = 0; b < 3; b++) begin
      syn = (k >= 2) ? rawh[b][k-2] : 1'b0;
      riseh[b][k] = 1'b0;
      if (syn != lvl[b]) begin
        streak[b]++;
        if (streak[b] == D) begin
          lvl[b] = syn; streak[b] = 0; riseh[b][k] = syn;
        end
      end else streak[b] = 0;
    end
    rs = (k >= 2) ? runh[k-2] : 1'b0;
    le = (k >= 2) && riseh[0][k-2];
    se = (k >= 2) && riseh[2][k-2];
    de = (k >= 3) && riseh[1][k-3];
    case (mmode)
      0: if (le) mmode = 3; else if (se) mmode = 2; else if (rs) begin mmode = 1; entry = k; end
      1: if (le) mmode = 3; else if (!rs) mmode = 0;
      2: mmode = 0;
      default: if (rs) begin mmode = 1; entry = k; end else mmode = 0;
    endcase
    if (de) mup = !mup;
    k++;
  endfunction

  function automatic logic [4:0] exp_vec();
    bit ld, ce;
    logic [1:0] m;
    ld = (mmode == 3);
    ce = (mmode == 2) || (mmode == 1 && ((k - 1 - entry) % T) == T - 1);
    m  = 2'(mmode);
    return {ld, ce, mup, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check(tag, 32'({Load, Count_en, Up, Mode}), 32'(exp_vec()));
    check("load_cen_excl", 32'(Load & Count_en), 32'd0);
  endtask

  task automatic do_reset_mid();
    #2 nReset = 1'b0;
    #1 check("rst_async", 32'({Load, Count_en, Up, Mode}), 32'd0);
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  initial begin
    int n, first, last, u;
    logic prev;

    model_reset();
    repeat (3) @(negedge Clk);
    check("reset", 32'({Load, Count_en, Up, Mode}), 32'd0);
    nReset = 1'b1;

    repeat (50) tick("idle");
    check("idle_end", 32'({Load, Count_en, Up, Mode}), 32'd0);

    // short bounce on load: no event
    n = 0;
    Btn_load = 1'b1;
    for (int i = 0; i < 3; i++) begin tick("bounce"); n += int'(Load); end
    Btn_load = 1'b0;
    for (int i = 0; i < 15; i++) begin tick("bounce"); n += int'(Load); end
    check("bounce_noload", 32'(n), 32'd0);

    // held load: one pulse after D+3 cycles
    n = 0; first = -1;
    Btn_load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick("load_hold");
      if (Load) begin n++; if (first < 0) first = i; end
    end
    check("load_count", 32'(n), 32'd1);
    check("load_latency", 32'(first), 32'(D + 3));
    Btn_load = 1'b0;
    repeat (10) tick("load_rel");
    check("load_mode", 32'(Mode), 32'd0);

    // free run with a step press in the middle
    n = 0; first = -1; last = -1;
    Run = 1'b1;
    for (int i = 0; i < 102; i++) begin
      if (i == 30) Btn_step = 1'b1;
      if (i == 40) Btn_step = 1'b0;
      tick("run");
      if (Count_en) begin
        n++;
        if (first < 0) first = i;
        else check("run_spacing", 32'(i - last), 32'(T));
        last = i;
      end
    end
    check("run_first", 32'(first), 32'(2 + T - 1));
    check("run_count", 32'(n), 32'd10);
    Run = 1'b0; n = 0;
    for (int i = 0; i < 15; i++) begin tick("run_stop"); n += int'(Count_en); end
    check("run_stop_ticks", 32'(n), 32'd0);
    check("run_stop_mode", 32'(Mode), 32'd0);

    // two step presses in idle
    n = 0;
    repeat (2) begin
      Btn_step = 1'b1;
      for (int i = 0; i < 8; i++) begin tick("step"); n += int'(Count_en); end
      Btn_step = 1'b0;
      for (int i = 0; i < 10; i++) begin tick("step"); n += int'(Count_en); end
    end
    check("step_count", 32'(n), 32'd2);

    // direction toggles
    Btn_dir = 1'b1; repeat (8) tick("dir"); Btn_dir = 1'b0; repeat (10) tick("dir");
    check("dir_up1", 32'(Up), 32'd1);
    Btn_dir = 1'b1; repeat (8) tick("dir"); Btn_dir = 1'b0; repeat (10) tick("dir");
    check("dir_up0", 32'(Up), 32'd0);

    // load and dir together
    n = 0; u = 0; prev = Up;
    Btn_load = 1'b1; Btn_dir = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin Btn_load = 1'b0; Btn_dir = 1'b0; end
      tick("ld_dir");
      n += int'(Load);
      if (Up != prev) u++;
      prev = Up;
    end
    check("ld_dir_load", 32'(n), 32'd1);
    check("ld_dir_up", 32'(u), 32'd1);

    // reset mid-RUN with prescaler at 5, Run held through reset
    Run = 1'b1;
    repeat (8) tick("pre_rst");
    do_reset_mid();
    first = -1;
    for (int i = 0; i < 25; i++) begin
      tick("post_rst");
      if (Count_en && first < 0) first = i;
    end
    check("rst_first_tick", 32'(first), 32'(2 + T - 1));
    Run = 1'b0;
    repeat (10) tick("post_rst");

    // randomized buttons, bounces, run toggles and occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(15) == 0) Btn_load = ~Btn_load;
      if ($urandom_range(15) == 0) Btn_dir  = ~Btn_dir;
      if ($urandom_range(15) == 0) Btn_step = ~Btn_step;
      if ($urandom_range(63) == 0) Run      = ~Run;
      if ($urandom_range(699) == 0) do_reset_mid();
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
